aes_key_sched: RTL and testbench

AES_KEY_SCHED -- requirements
Module: aes_key_sched

---
 rtl/aes_pkg.sv | 67 ++++++
 rtl/aes_sbox.sv | 10 +
 rtl/aes_sub_word.sv | 22 ++
 rtl/aes_key_sched.sv | 208 ++++++++++++++++++++
 tb/tb_aes_key_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: word type, key-length encoding, S-box and Rcon tables,
// and the key-length to NK/Nr lookups used by the key schedule.
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        KLEN_128 = 2'd0,
        KLEN_192 = 2'd1,
        KLEN_256 = 2'd2,
        KLEN_BAD = 2'd3
    } klen_e;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] j);
        case (j)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] nk_of(input klen_e k);
        case (k)
            KLEN_128: return 4'd4;
            KLEN_192: return 4'd6;
            KLEN_256: return 4'd8;
            default:  return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input klen_e k);
        return nk_of(k) + 4'd6;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte forward AES S-box lookup.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    import aes_pkg::*;

    assign out_byte = sbox(in_byte);

endmodule

// File: rtl/aes_sub_word.sv
// SubWord with optional RotWord ahead of it and an Rcon byte folded into the top byte.
module aes_sub_word (
    input  logic [31:0] word_in,
    input  logic        rot_en,
    input  logic [7:0]  rcon_in,
    output logic [31:0] word_out
);
    logic [31:0] rot_w;
    logic [31:0] sub_w;

    assign rot_w = rot_en ? {word_in[23:0], word_in[31:24]} : word_in;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_w[8*b +: 8]),
            .out_byte (sub_w[8*b +: 8])
        );
    end

    assign word_out = sub_w ^ {rcon_in, 24'h0};

endmodule

// File: rtl/aes_key_sched.sv
// AES-128/192/256 key expansion, one word per cycle, round keys streamed with valid/ready.
// Optional macro AES_KS_LAST_KEY_EN adds the last_key output (final round key, decrypt start).
module aes_key_sched #(
    parameter int NK_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            klen,
    input  logic [32*NK_MAX-1:0]  key_in,
    output logic                  busy,
    output logic                  rk_valid,
    input  logic                  rk_ready,
    output logic [127:0]          rk_out,
    output logic [3:0]            rk_idx,
    output logic                  done,
    output logic                  err
`ifdef AES_KS_LAST_KEY_EN
    ,
    output logic [127:0]          last_key
`endif
);
    import aes_pkg::*;

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_e;

    state_e       state_q, state_d;
    klen_e        klen_q, klen_d;
    word_t        win_q [NK_MAX];
    word_t        win_d [NK_MAX];
    logic [3:0]   mcnt_q, mcnt_d;
    logic [3:0]   rcj_q, rcj_d;
    logic [3:0]   rk_idx_q, rk_idx_d;
    logic [1:0]   wpos_q, wpos_d;
    logic [127:0] rk_out_q, rk_out_d;
    logic         busy_q, busy_d;
    logic         rk_valid_q, rk_valid_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
`ifdef AES_KS_LAST_KEY_EN
    logic [127:0] last_key_q, last_key_d;
`endif

    klen_e        klen_in;
    logic [3:0]   nk, nr;
    word_t        newest, sub_out, temp, new_w;
    logic [7:0]   rcon_sel;
    logic [127:0] rk_buf;
    logic         use_rot, use_sub, hs, last_hs, gen;

    assign klen_in = klen_e'(klen);

    // The window always emits its oldest word and appends the word NK positions later.
    always_comb begin
        nk     = nk_of(klen_q);
        nr     = nr_of(klen_q);
        newest = win_q[0];
        for (int k = 0; k < NK_MAX; k++) begin
            if (k == int'(nk) - 1) newest = win_q[k];
        end
        use_rot  = (mcnt_q == 4'd0);
        use_sub  = use_rot || (nk == 4'd8 && mcnt_q == 4'd4);
        rcon_sel = use_rot ? rcon(rcj_q) : 8'h00;
    end

    aes_sub_word u_sub_word (
        .word_in  (newest),
        .rot_en   (use_rot),
        .rcon_in  (rcon_sel),
        .word_out (sub_out)
    );

    always_comb begin
        state_d    = state_q;
        klen_d     = klen_q;
        win_d      = win_q;
        mcnt_d     = mcnt_q;
        rcj_d      = rcj_q;
        rk_idx_d   = rk_idx_q;
        wpos_d     = wpos_q;
        rk_out_d   = rk_out_q;
        busy_d     = busy_q;
        rk_valid_d = rk_valid_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
`ifdef AES_KS_LAST_KEY_EN
        last_key_d = last_key_q;
`endif
        temp    = use_sub ? sub_out : newest;
        new_w   = win_q[0] ^ temp;
        hs      = rk_valid_q && rk_ready;
        last_hs = hs && (rk_idx_q == nr);
        gen     = (state_q == S_EXPAND) && (!rk_valid_q || (hs && !last_hs));
        rk_buf  = hs ? 128'h0 : rk_out_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (klen_in == KLEN_BAD || int'(nk_of(klen_in)) > NK_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = S_EXPAND;
                        busy_d     = 1'b1;
                        klen_d     = klen_in;
                        mcnt_d     = 4'd0;
                        rcj_d      = 4'd1;
                        wpos_d     = 2'd0;
                        rk_idx_d   = 4'd0;
                        rk_out_d   = 128'h0;
                        rk_valid_d = 1'b0;
`ifdef AES_KS_LAST_KEY_EN
                        last_key_d = 128'h0;
`endif
                        for (int k = 0; k < NK_MAX; k++) begin
                            win_d[k] = key_in[32*(NK_MAX-k)-1 -: 32];
                        end
                    end
                end
            end
            S_EXPAND: begin
                if (hs) begin
                    rk_valid_d = 1'b0;
                    if (!last_hs) rk_idx_d = rk_idx_q + 4'd1;
                end
                if (last_hs) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef AES_KS_LAST_KEY_EN
                    last_key_d = rk_out_q;
`endif
                end
                if (gen) begin
                    case (wpos_q)
                        2'd0:    rk_buf[127:96] = win_q[0];
                        2'd1:    rk_buf[95:64]  = win_q[0];
                        2'd2:    rk_buf[63:32]  = win_q[0];
                        default: rk_buf[31:0]   = win_q[0];
                    endcase
                    rk_out_d = rk_buf;
                    wpos_d   = wpos_q + 2'd1;
                    if (wpos_q == 2'd3) rk_valid_d = 1'b1;
                    for (int k = 0; k < NK_MAX - 1; k++) begin
                        if (k < int'(nk) - 1) win_d[k] = win_q[k+1];
                    end
                    for (int k = 0; k < NK_MAX; k++) begin
                        if (k == int'(nk) - 1) win_d[k] = new_w;
                    end
                    if (mcnt_q == nk - 4'd1) begin
                        mcnt_d = 4'd0;
                        rcj_d  = rcj_q + 4'd1;
                    end else begin
                        mcnt_d = mcnt_q + 4'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            klen_q     <= KLEN_128;
            mcnt_q     <= 4'd0;
            rcj_q      <= 4'd0;
            rk_idx_q   <= 4'd0;
            wpos_q     <= 2'd0;
            rk_out_q   <= 128'h0;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef AES_KS_LAST_KEY_EN
            last_key_q <= 128'h0;
`endif
            for (int k = 0; k < NK_MAX; k++) win_q[k] <= 32'h0;
        end else begin
            state_q    <= state_d;
            klen_q     <= klen_d;
            mcnt_q     <= mcnt_d;
            rcj_q      <= rcj_d;
            rk_idx_q   <= rk_idx_d;
            wpos_q     <= wpos_d;
            rk_out_q   <= rk_out_d;
            busy_q     <= busy_d;
            rk_valid_q <= rk_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef AES_KS_LAST_KEY_EN
            last_key_q <= last_key_d;
`endif
            for (int k = 0; k < NK_MAX; k++) win_q[k] <= win_d[k];
        end
    end

    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk_out   = rk_out_q;
    assign rk_idx   = rk_idx_q;
    assign done     = done_q;
    assign err      = err_q;
`ifdef AES_KS_LAST_KEY_EN
    assign last_key = last_key_q;
`endif

endmodule

// File: tb/tb_aes_key_sched.sv
// Bench for aes_key_sched: independent key-expansion model feeding a round-key scoreboard,
// plus FIPS-197 known answers, backpressure, error, busy-start and mid-run reset scenarios.
module tb_aes_key_sched;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst, start, rk_ready;
    logic [1:0]   klen;
    logic [255:0] key_in;
    logic         busy, rk_valid, done, err;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
`ifdef AES_KS_LAST_KEY_EN
    logic [127:0] last_key;
`endif

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [7:0]   sbox_t [256];
    logic [31:0]  w_ref [60];
    logic [131:0] sb [$];
    logic [127:0] got_rk [16];

    aes_key_sched #(.NK_MAX(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .klen     (klen),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .done     (done),
        .err      (err)
`ifdef AES_KS_LAST_KEY_EN
        ,
        .last_key (last_key)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got no finish exp finish before 500us");
        $fatal(1);
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from the GF(2^8) inverse and the affine transform.
    task automatic build_sbox();
        logic [7:0] inv, bb;
        for (int b = 0; b < 256; b++) begin
            bb  = 8'(b);
            inv = 8'h00;
            if (bb != 8'h00) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, bb);
            end
            sbox_t[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    task automatic model_push(input logic [255:0] key, input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nk + 7); i++) begin
            if (i < nk) begin
                w_ref[i] = key[255 - 32*i -: 32];
            end else begin
                t = w_ref[i-1];
                if (i % nk == 0) begin
                    t = subw({t[23:0], t[31:24]});
                    t[31:24] = t[31:24] ^ rc;
                    rc = xt(rc);
                end else if (nk == 8 && i % nk == 4) begin
                    t = subw(t);
                end
                w_ref[i] = w_ref[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nk + 6; r++)
            sb.push_back({4'(r), w_ref[4*r], w_ref[4*r+1], w_ref[4*r+2], w_ref[4*r+3]});
    endtask

    task automatic run_key(input logic [1:0] kl, input logic [255:0] key, input bit rnd,
                           input bit poke, output int done_cyc, output int first_v,
                           output int n_keys);
        int           cyc;
        bit           hold;
        logic [127:0] hold_k;
        logic [3:0]   hold_i;
        logic [131:0] exp_e;
        for (int r = 0; r < 16; r++) got_rk[r] = 128'h0;
        model_push(key, 4 + 2 * int'(kl));
        done_cyc = -1; first_v = -1; n_keys = 0; hold = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; klen = kl; key_in = key; rk_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; klen = 2'd1; key_in = ~key;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_on_accept got %b exp 1", busy);
        end
        cyc = 0;
        while (cyc < 400 && done_cyc < 0) begin
            if (hold) begin
                n_tests++;
                if ({rk_valid, rk_idx, rk_out} !== {1'b1, hold_i, hold_k}) begin
                    n_fail++;
                    $display("FAIL stall_hold got v%b idx %0d %h exp v1 idx %0d %h",
                             rk_valid, rk_idx, rk_out, hold_i, hold_k);
                end
            end
            if (rk_valid && first_v < 0) first_v = cyc;
            if (poke && cyc == 10) begin start = 1'b1; klen = 2'd2; key_in = {8{$urandom()}}; end
            if (poke && cyc == 13) start = 1'b0;
            if (done === 1'b1) begin
                done_cyc = cyc;
            end else begin
                rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                hold = rk_valid && !rk_ready;
                hold_k = rk_out; hold_i = rk_idx;
                if (rk_valid && rk_ready) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++; $display("FAIL extra_key got idx %0d exp none", rk_idx);
                    end else begin
                        exp_e = sb.pop_front();
                        if ({rk_idx, rk_out} !== exp_e) begin
                            n_fail++;
                            $display("FAIL round_key got idx %0d %h exp idx %0d %h",
                                     rk_idx, rk_out, exp_e[131:128], exp_e[127:0]);
                        end
                        got_rk[rk_idx] = rk_out;
                        n_keys++;
                    end
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        n_tests++;
        if (done_cyc < 0) begin
            n_fail++; $display("FAIL run_timeout got no done exp done within 400 cycles");
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL keys_left got %0d exp 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
        n_tests++;
        if ({done, busy} !== 2'b00) begin
            n_fail++; $display("FAIL done_pulse got done %b busy %b exp 0 0", done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, rk_valid, done, err, rk_idx, rk_out} !== 136'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got b%b v%b d%b e%b idx %0d %h exp all 0",
                     busy, rk_valid, done, err, rk_idx, rk_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_aes128();
        int dc, fv, nk;
        run_key(2'd0, {K128, 128'h0}, 1'b0, 1'b0, dc, fv, nk);
        n_tests++;
        if (dc != 45) begin n_fail++; $display("FAIL done_cycle_128 got %0d exp 45", dc); end
        n_tests++;
        if (fv != 4) begin n_fail++; $display("FAIL first_valid got %0d exp 4", fv); end
        n_tests++;
        if (got_rk[0] !== K128) begin n_fail++; $display("FAIL rk0_128 got %h exp %h", got_rk[0], K128); end
        n_tests++;
        if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            n_fail++; $display("FAIL rk1_128 got %h exp a0fafe1788542cb123a339392a6c7605", got_rk[1]);
        end
        n_tests++;
        if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_fail++; $display("FAIL rk10_128 got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]);
        end
        n_tests++;
        if (nk != 11) begin n_fail++; $display("FAIL key_count_128 got %0d exp 11", nk); end
    endtask

    task automatic test_aes192();
        int dc, fv, nk;
        run_key(2'd1, {K192, 64'h0}, 1'b0, 1'b0, dc, fv, nk);
        n_tests++;
        if (got_rk[12] !== 128'he98ba06f448c773c8ecc720401002202) begin
            n_fail++; $display("FAIL rk12_192 got %h exp e98ba06f448c773c8ecc720401002202", got_rk[12]);
        end
        n_tests++;
        if (nk != 13) begin n_fail++; $display("FAIL key_count_192 got %0d exp 13", nk); end
        n_tests++;
        if (dc != 53) begin n_fail++; $display("FAIL done_cycle_192 got %0d exp 53", dc); end
    endtask

    task automatic test_aes256();
        int dc, fv, nk;
        run_key(2'd2, K256, 1'b0, 1'b0, dc, fv, nk);
        n_tests++;
        if (got_rk[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            n_fail++; $display("FAIL rk14_256 got %h exp fe4890d1e6188d0b046df344706c631e", got_rk[14]);
        end
        n_tests++;
        if (nk != 15) begin n_fail++; $display("FAIL key_count_256 got %0d exp 15", nk); end
        n_tests++;
        if (dc != 61) begin n_fail++; $display("FAIL done_cycle_256 got %0d exp 61", dc); end
`ifdef AES_KS_LAST_KEY_EN
        n_tests++;
        if (last_key !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            n_fail++; $display("FAIL last_key got %h exp fe4890d1e6188d0b046df344706c631e", last_key);
        end
`endif
    endtask

    task automatic test_backpressure();
        int dc, fv, nk;
        run_key(2'd0, {K128, 128'h0}, 1'b1, 1'b0, dc, fv, nk);
        n_tests++;
        if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_fail++; $display("FAIL rk10_bp got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]);
        end
        n_tests++;
        if (nk != 11) begin n_fail++; $display("FAIL key_count_bp got %0d exp 11", nk); end
    endtask

    task automatic test_start_while_busy();
        int dc, fv, nk;
        run_key(2'd0, {K128, 128'h0}, 1'b0, 1'b1, dc, fv, nk);
        n_tests++;
        if (dc != 45) begin n_fail++; $display("FAIL done_cycle_poke got %0d exp 45", dc); end
        n_tests++;
        if (nk != 11) begin n_fail++; $display("FAIL key_count_poke got %0d exp 11", nk); end
    endtask

    task automatic test_err();
        @(posedge clk); #1;
        start = 1'b1; klen = 2'd3; key_in = {K128, 128'h0};
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++;
        if ({err, busy} !== 2'b10) begin
            n_fail++; $display("FAIL err_pulse got err %b busy %b exp 1 0", err, busy);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({err, busy, rk_valid} !== 3'b000) begin
            n_fail++; $display("FAIL err_after got err %b busy %b v %b exp 0 0 0", err, busy, rk_valid);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, dc, fv, nk;
        @(posedge clk); #1;
        start = 1'b1; klen = 2'd0; key_in = {K128, 128'h0}; rk_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(rk_valid === 1'b1 && rk_idx === 4'd5) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_tests++;
        if (cyc >= 100) begin n_fail++; $display("FAIL reach_rk5 got timeout exp rk_idx 5"); end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({busy, rk_valid, done, err, rk_idx, rk_out} !== 136'h0) begin
            n_fail++;
            $display("FAIL mid_reset got b%b v%b d%b e%b idx %0d %h exp all 0",
                     busy, rk_valid, done, err, rk_idx, rk_out);
        end
`ifdef AES_KS_LAST_KEY_EN
        n_tests++;
        if (last_key !== 128'h0) begin n_fail++; $display("FAIL mid_reset_last got %h exp 0", last_key); end
`endif
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, rk_valid} !== 2'b00) begin
            n_fail++; $display("FAIL reset_held got b%b v%b exp 0 0", busy, rk_valid);
        end
        rst = 1'b0;
        run_key(2'd0, {K128, 128'h0}, 1'b0, 1'b0, dc, fv, nk);
        n_tests++;
        if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_fail++; $display("FAIL rk10_after_rst got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]);
        end
        n_tests++;
        if (nk != 11) begin n_fail++; $display("FAIL key_count_after_rst got %0d exp 11", nk); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; klen = 2'd0; key_in = 256'h0; rk_ready = 1'b0;
        build_sbox();
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_backpressure();
        test_err();
        test_start_while_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
